// File: rtl/intra16_mode_decision.sv
// Intra 16x16 mode decision: Vertical / Horizontal / DC SAD evaluation for one macroblock.
// Latency: done pulses 18 cycles after the accepting start edge (1 DC cycle, 16 row cycles, 1 decide cycle).
// Backpressure: none; start is ignored while a macroblock is in flight, except on the decide edge itself.
//
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   start                   - evaluate current inputs (accepted in IDLE, or on the DECIDE edge)
//   mb / toppixels / leftpixels / top_avail / left_avail - macroblock and neighbour data, captured at start
//   busy, done              - in-flight flag, one-cycle result strobe
//   best_mode, best_sad, dc_value - results (0=V, 1=H, 2=DC), held until next done or reset
module intra16_mode_decision #(
    parameter int MB_SIZE_L = 16,
    parameter int MB_SIZE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  mb         [0:MB_SIZE_L*MB_SIZE_W-1],
    input  logic [7:0]  toppixels  [0:MB_SIZE_W-1],
    input  logic [7:0]  leftpixels [0:MB_SIZE_L-1],
    input  logic        top_avail,
    input  logic        left_avail,
    output logic        busy,
    output logic        done,
    output logic [1:0]  best_mode,
    output logic [15:0] best_sad,
    output logic [7:0]  dc_value
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DCCALC = 2'd1,
        ST_ROWS   = 2'd2,
        ST_DECIDE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_V  = 2'd0;
    localparam logic [1:0] MODE_H  = 2'd1;
    localparam logic [1:0] MODE_DC = 2'd2;

    state_t      r_state;
    logic [3:0]  r_row;
    logic [7:0]  r_dc;
    logic [15:0] r_sad_v;
    logic [15:0] r_sad_h;
    logic [15:0] r_sad_dc;

    // Captured macroblock and neighbours; data only, so no reset needed.
    logic [7:0]  r_mb   [0:MB_SIZE_L*MB_SIZE_W-1];
    logic [7:0]  r_top  [0:MB_SIZE_W-1];
    logic [7:0]  r_left [0:MB_SIZE_L-1];
    logic        r_top_av;
    logic        r_left_av;

    logic        w_accept;
    logic [11:0] w_sum_top;
    logic [11:0] w_sum_left;
    logic [12:0] w_sum_both;
    logic [11:0] w_sum_top_rnd;
    logic [11:0] w_sum_left_rnd;
    logic [7:0]  w_dc;
    logic [7:0]  w_pix;
    logic [11:0] w_row_v;
    logic [11:0] w_row_h;
    logic [11:0] w_row_dc;
    logic [1:0]  w_sel_mode;
    logic [15:0] w_sel_sad;
    logic        w_have;

    function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // A start on the DECIDE edge is taken so back-to-back macroblocks run at
    // one per 18 cycles: the FSM leaves DECIDE on that same edge.
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DECIDE));

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mb      <= mb;
            r_top     <= toppixels;
            r_left    <= leftpixels;
            r_top_av  <= top_avail;
            r_left_av <= left_avail;
        end
    end

    // DC predictor from the captured neighbours.
    always_comb begin
        w_sum_top  = '0;
        w_sum_left = '0;
        for (int c = 0; c < MB_SIZE_W; c++) begin
            w_sum_top = w_sum_top + {4'd0, r_top[4'(c)]};
        end
        for (int r = 0; r < MB_SIZE_L; r++) begin
            w_sum_left = w_sum_left + {4'd0, r_left[4'(r)]};
        end
        w_sum_both     = {1'b0, w_sum_top} + {1'b0, w_sum_left} + 13'd16;
        w_sum_top_rnd  = w_sum_top + 12'd8;
        w_sum_left_rnd = w_sum_left + 12'd8;
        case ({r_top_av, r_left_av})
            2'b11:   w_dc = 8'(w_sum_both >> 5);
            2'b10:   w_dc = 8'(w_sum_top_rnd >> 4);
            2'b01:   w_dc = 8'(w_sum_left_rnd >> 4);
            default: w_dc = 8'd128;
        endcase
    end

    // Per-row SAD for the row selected by r_row, all three modes in parallel.
    always_comb begin
        w_pix    = '0;
        w_row_v  = '0;
        w_row_h  = '0;
        w_row_dc = '0;
        for (int c = 0; c < MB_SIZE_W; c++) begin
            w_pix    = r_mb[{r_row, 4'(c)}];
            w_row_v  = w_row_v  + {4'd0, absdiff(w_pix, r_top[4'(c)])};
            w_row_h  = w_row_h  + {4'd0, absdiff(w_pix, r_left[r_row])};
            w_row_dc = w_row_dc + {4'd0, absdiff(w_pix, r_dc)};
        end
    end

    // Minimum over legal modes; evaluating V, H, DC in that order with a
    // strict compare gives ties to the earlier mode. DC is always legal.
    always_comb begin
        w_have     = 1'b0;
        w_sel_mode = MODE_DC;
        w_sel_sad  = r_sad_dc;
        if (r_top_av) begin
            w_have     = 1'b1;
            w_sel_mode = MODE_V;
            w_sel_sad  = r_sad_v;
        end
        if (r_left_av && (!w_have || (r_sad_h < w_sel_sad))) begin
            w_have     = 1'b1;
            w_sel_mode = MODE_H;
            w_sel_sad  = r_sad_h;
        end
        if (w_have && !(r_sad_dc < w_sel_sad)) begin
            w_sel_mode = w_sel_mode;
        end else begin
            w_sel_mode = MODE_DC;
            w_sel_sad  = r_sad_dc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_row     <= '0;
            r_dc      <= '0;
            r_sad_v   <= '0;
            r_sad_h   <= '0;
            r_sad_dc  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            best_mode <= '0;
            best_sad  <= '0;
            dc_value  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sad_v  <= '0;
                        r_sad_h  <= '0;
                        r_sad_dc <= '0;
                        r_row    <= '0;
                        busy     <= 1'b1;
                        r_state  <= ST_DCCALC;
                    end
                end
                ST_DCCALC: begin
                    r_dc    <= w_dc;
                    r_state <= ST_ROWS;
                end
                ST_ROWS: begin
                    r_sad_v  <= r_sad_v  + {4'd0, w_row_v};
                    r_sad_h  <= r_sad_h  + {4'd0, w_row_h};
                    r_sad_dc <= r_sad_dc + {4'd0, w_row_dc};
                    r_row    <= r_row + 4'd1;
                    if (r_row == 4'(MB_SIZE_L - 1)) begin
                        r_state <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    best_mode <= w_sel_mode;
                    best_sad  <= w_sel_sad;
                    dc_value  <= r_dc;
                    done      <= 1'b1;
                    if (start) begin
                        r_sad_v  <= '0;
                        r_sad_h  <= '0;
                        r_sad_dc <= '0;
                        r_row    <= '0;
                        busy     <= 1'b1;
                        r_state  <= ST_DCCALC;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intra16_mode_decision.sv
module tb_intra16_mode_decision;

    localparam int L = 16;
    localparam int W = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  mb         [0:L*W-1];
    logic [7:0]  toppixels  [0:W-1];
    logic [7:0]  leftpixels [0:L-1];
    logic        top_avail = 1'b1;
    logic        left_avail = 1'b1;
    logic        busy;
    logic        done;
    logic [1:0]  best_mode;
    logic [15:0] best_sad;
    logic [7:0]  dc_value;

    intra16_mode_decision #(.MB_SIZE_L(L), .MB_SIZE_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mb         (mb),
        .toppixels  (toppixels),
        .leftpixels (leftpixels),
        .top_avail  (top_avail),
        .left_avail (left_avail),
        .busy       (busy),
        .done       (done),
        .best_mode  (best_mode),
        .best_sad   (best_sad),
        .dc_value   (dc_value)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] sad;
        logic [7:0]  dc;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes done.
    always @(negedge clk) begin
        if (done) begin
            check("done_single_pulse", 32'(prev_done), 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("best_mode", 32'(best_mode), 32'(mon_e.mode));
                check("best_sad", 32'(best_sad), 32'(mon_e.sad));
                check("dc_value", 32'(dc_value), 32'(mon_e.dc));
                check("done_cycle", 32'(cyc), 32'(mon_e.due));
            end
        end
        prev_done = done;
    end

    task automatic fill(input logic [7:0] vm, input logic [7:0] vt, input logic [7:0] vl);
        for (int i = 0; i < L*W; i++) mb[i] = vm;
        for (int i = 0; i < W; i++) toppixels[i] = vt;
        for (int i = 0; i < L; i++) leftpixels[i] = vl;
    endtask

    // Called at a negedge: start is sampled at the next posedge, done 18 edges later.
    task automatic issue(input logic [1:0] m, input logic [15:0] s, input logic [7:0] d);
        exp_t e;
        e.mode = m;
        e.sad  = s;
        e.dc   = d;
        e.due  = cyc + 19;
        sb.push_back(e);
        start = 1'b1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got %0d results pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    int t0;

    initial begin
        fill(8'd0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mode", 32'(best_mode), 32'd0);
        check("rst_sad", 32'(best_sad), 32'd0);
        check("rst_dc", 32'(dc_value), 32'd0);

        // Flat 128: zero SAD everywhere, tie goes to Vertical.
        fill(8'd128, 8'd128, 8'd128);
        top_avail = 1'b1;
        left_avail = 1'b1;
        issue(2'd0, 16'd0, 8'd128);
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        // Inputs change after capture; the result must not move.
        fill(8'd0, 8'd200, 8'd50);
        top_avail = 1'b0;
        wait_until(t0 + 4);
        start = 1'b1;                 // sampled at T5 while busy: ignored
        @(negedge clk);
        start = 1'b0;

        // Horizontal ramp, started on the done edge T18.
        wait_until(t0 + 17);
        top_avail = 1'b1;
        left_avail = 1'b1;
        for (int r = 0; r < L; r++) begin
            leftpixels[r] = 8'(10 * r);
            for (int c = 0; c < W; c++) mb[r*L + c] = 8'(10 * r);
        end
        for (int c = 0; c < W; c++) toppixels[c] = 8'd0;
        issue(2'd1, 16'd0, 8'd38);
        @(negedge clk);
        start = 1'b0;
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_busy", 32'(busy), 32'd1);
        drain();

        // Extreme: all 255 against zero neighbours.
        @(negedge clk);
        fill(8'd255, 8'd0, 8'd0);
        issue(2'd0, 16'd65280, 8'd0);
        @(negedge clk);
        start = 1'b0;
        drain();

        // No neighbours: only DC is legal even though V/H would be zero cost.
        @(negedge clk);
        fill(8'd100, 8'd100, 8'd100);
        top_avail = 1'b0;
        left_avail = 1'b0;
        issue(2'd2, 16'd7168, 8'd128);
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        check("hold_mode", 32'(best_mode), 32'd2);
        check("hold_sad", 32'(best_sad), 32'd7168);
        check("hold_dc", 32'(dc_value), 32'd128);

        // Reset mid-operation: no result for the discarded macroblock.
        fill(8'd128, 8'd128, 8'd128);
        top_avail = 1'b1;
        left_avail = 1'b1;
        start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        wait_until(t0 + 8);
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_mode", 32'(best_mode), 32'd0);
        check("midrst_sad", 32'(best_sad), 32'd0);
        check("midrst_dc", 32'(dc_value), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("post_rst_idle_busy", 32'(busy), 32'd0);
        issue(2'd0, 16'd0, 8'd128);
        @(negedge clk);
        start = 1'b0;
        drain();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
